// File: rtl/serial_line_driver_if.sv
// Single-bit serial line shared between one transmitter and its samplers.
interface serial_line_driver_if;
  logic c;

  // Transmitting end drives the line.
  modport master (output c);
  // Receiving ends only observe the line.
  modport slave  (input  c);
endinterface

// File: rtl/serial_line_driver.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit,
// each bit held for BIT_CYCLES clocks. One word per valid/ready handshake.
module serial_line_driver #(
  parameter int   WIDTH      = 10,
  parameter int   BIT_CYCLES = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_c,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic             last_cyc;

  assign last_cyc = (cyc_q == CYC_LAST);

  // Next-state logic; line level and done are derived from the next state so
  // they can be registered and appear in the same cycle as the state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_START;
          shreg_d = i_data;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (last_cyc) begin
          state_d = ST_DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (last_cyc) begin
          cyc_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        if (last_cyc) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase

    case (state_d)
      ST_START: c_d = ~IDLE_LEVEL;
      ST_DATA:  c_d = shreg_d[0];
      default:  c_d = IDLE_LEVEL;
    endcase

    done_d = (state_d == ST_STOP) && (cyc_d == CYC_LAST);
  end

  // State registers; reset abandons any frame in flight and wins over a handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      c_q     <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_c     = c_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_serial_line_driver.sv
// Scoreboard bench: each accepted word pushes its expected per-clock line
// level and done flag; scenario tasks pop and compare once per clock.
module tb_serial_line_driver;

  logic       clk;
  logic       rst;
  logic [9:0] data;
  logic       valid;
  logic       ready, busy, done;
  logic [0:0] data1;
  logic       valid1;
  logic       ready1, busy1, done1;

  serial_line_driver_if line_if ();
  serial_line_driver_if line1_if ();

  serial_line_driver #(.WIDTH(10), .BIT_CYCLES(4), .IDLE_LEVEL(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_c(line_if.c), .o_busy(busy), .o_done(done)
  );

  serial_line_driver #(.WIDTH(1), .BIT_CYCLES(1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .o_c(line1_if.c), .o_busy(busy1), .o_done(done1)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc_cnt  = 0;
  int hs_cnt   = 0;
  int hs_cyc [$];
  logic [1:0] exp_q [$];   // {c, done}
  logic [1:0] exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor for the default-parameter instance.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst && valid && ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_cyc.push_back(cyc_cnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame: start 0, data LSB first, stop 1, 4 clocks each.
  task automatic push_frame(input logic [9:0] w);
    logic lvl;
    for (int s = 0; s < 12; s++) begin
      if (s == 0) lvl = 1'b0;
      else if (s == 11) lvl = 1'b1;
      else lvl = w[s-1];
      for (int k = 0; k < 4; k++) exp_q.push_back({lvl, (s == 11 && k == 3)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; data = 10'h3FF; valid1 = 1'b1; data1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (line_if.c !== 1'b1) $display("FAIL reset_c got=%b exp=1", line_if.c); else pass_cnt++;
    chk_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    chk_cnt++; if (line1_if.c !== 1'b1 || busy1 !== 1'b0) $display("FAIL reset_corner c=%b busy=%b exp c=1 busy=0", line1_if.c, busy1); else pass_cnt++;
    valid = 1'b0; valid1 = 1'b0;
    rst = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_single_frame(input logic [9:0] w);
    @(negedge clk);
    chk_cnt++; if (ready !== 1'b1) $display("FAIL single_ready_pre got=%b exp=1", ready); else pass_cnt++;
    valid = 1'b1; data = w; push_frame(w);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1]) $display("FAIL single_c clk=%0d got=%b exp=%b", k + 1, line_if.c, exp[1]); else pass_cnt++;
      chk_cnt++; if (done !== exp[0]) $display("FAIL single_done clk=%0d got=%b exp=%b", k + 1, done, exp[0]); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy clk=%0d got=%b exp=1", k + 1, busy); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (ready !== 1'b1 || line_if.c !== 1'b1) $display("FAIL single_idle ready=%b c=%b exp 1/1", ready, line_if.c); else pass_cnt++;
    $display("frame: word=%h sent", w);
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_cnt;
    @(negedge clk);
    valid = 1'b1; data = 10'h001; push_frame(10'h001);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) data = 10'h3FF;
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1] || done !== exp[0]) $display("FAIL b2b_first clk=%0d c=%b done=%b exp %b/%b", k + 1, line_if.c, done, exp[1], exp[0]); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (line_if.c !== 1'b1 || ready !== 1'b1) $display("FAIL b2b_gap c=%b ready=%b exp 1/1", line_if.c, ready); else pass_cnt++;
    push_frame(10'h3FF);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1] || done !== exp[0]) $display("FAIL b2b_second clk=%0d c=%b done=%b exp %b/%b", k + 1, line_if.c, done, exp[1], exp[0]); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (hs_cnt - hs0 !== 2) $display("FAIL b2b_handshakes got=%0d exp=2", hs_cnt - hs0); else pass_cnt++;
    chk_cnt++;
    if (hs_cyc.size() < 2 || hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2] !== 49)
      $display("FAIL b2b_spacing got=%0d exp=49", (hs_cyc.size() < 2) ? -1 : hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]);
    else pass_cnt++;
    $display("back_to_back: words 001,3ff sent");
  endtask

  task automatic test_data_stability();
    @(negedge clk);
    valid = 1'b1; data = 10'h155; push_frame(10'h155);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      data = 10'($urandom);
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1] || done !== exp[0]) $display("FAIL stable clk=%0d c=%b done=%b exp %b/%b", k + 1, line_if.c, done, exp[1], exp[0]); else pass_cnt++;
    end
    @(negedge clk);
    $display("stability: word=155 sent with changing input");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    valid = 1'b1; data = 10'h2A5; push_frame(10'h2A5);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1]) $display("FAIL midrst_pre clk=%0d c=%b exp=%b", k + 1, line_if.c, exp[1]); else pass_cnt++;
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_cnt++; if (line_if.c !== 1'b1) $display("FAIL midrst_c got=%b exp=1", line_if.c); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || ready !== 1'b1) $display("FAIL midrst_state busy=%b ready=%b exp 0/1", busy, ready); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else pass_cnt++;
    rst = 1'b1; valid = 1'b1; data = 10'h2A5; push_frame(10'h2A5);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1] || done !== exp[0]) $display("FAIL midrst_post clk=%0d c=%b done=%b exp %b/%b", k + 1, line_if.c, done, exp[1], exp[0]); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (ready !== 1'b1) $display("FAIL midrst_ready_end got=%b exp=1", ready); else pass_cnt++;
    $display("mid_reset: frame abandoned, word=2a5 resent");
  endtask

  task automatic test_corner(input logic b);
    logic [1:0] cq [$];
    logic [1:0] e;
    @(negedge clk);
    valid1 = 1'b1; data1 = b;
    cq.push_back(2'b00); cq.push_back({b, 1'b0}); cq.push_back(2'b11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) valid1 = 1'b0;
      e = cq.pop_front();
      chk_cnt++; if (line1_if.c !== e[1] || done1 !== e[0]) $display("FAIL corner_b%0b clk=%0d c=%b done=%b exp %b/%b", b, k + 1, line1_if.c, done1, e[1], e[0]); else pass_cnt++;
      chk_cnt++; if (busy1 !== 1'b1) $display("FAIL corner_busy clk=%0d got=%b exp=1", k + 1, busy1); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (ready1 !== 1'b1 || line1_if.c !== 1'b1) $display("FAIL corner_idle ready=%b c=%b exp 1/1", ready1, line1_if.c); else pass_cnt++;
    $display("corner: W=1 B=1 bit=%b sent", b);
  endtask

  task automatic test_ignore_busy();
    int hs0;
    @(negedge clk);
    valid = 1'b1; data = 10'h0F0; push_frame(10'h0F0);
    hs0 = hs_cnt;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      valid = (k == 10 || k == 30);
      data  = 10'h3C3;
      if (k == 10) begin
        chk_cnt++; if (ready !== 1'b0) $display("FAIL ignore_ready got=%b exp=0", ready); else pass_cnt++;
      end
      exp = exp_q.pop_front();
      chk_cnt++; if (line_if.c !== exp[1] || done !== exp[0]) $display("FAIL ignore_frame clk=%0d c=%b done=%b exp %b/%b", k + 1, line_if.c, done, exp[1], exp[0]); else pass_cnt++;
    end
    valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_cnt++; if (line_if.c !== 1'b1 || busy !== 1'b0) $display("FAIL ignore_idle clk=%0d c=%b busy=%b exp 1/0", k, line_if.c, busy); else pass_cnt++;
    end
    chk_cnt++; if (hs_cnt - hs0 !== 1) $display("FAIL ignore_handshakes got=%0d exp=1", hs_cnt - hs0); else pass_cnt++;
    $display("ignore_busy: word=0f0 sent, extra valid ignored");
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
    test_reset();
    test_single_frame(10'h2A5);
    test_back_to_back();
    test_data_stability();
    test_mid_reset();
    test_corner(1'b0);
    test_corner(1'b1);
    test_ignore_busy();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
